// File: rtl/vga_sync_receiver.sv
// Receive side of the VGA sync-pulse interface: registers the incoming
// hsync/vsync/RGB stream, regenerates col/row counters aligned to the pixel
// data, checks line and frame timing, and reports lock and violations.
module vga_sync_receiver #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ihsync,
  input  logic                   ivsync,
  input  logic [VIDEO_WIDTH-1:0] iredv,
  input  logic [VIDEO_WIDTH-1:0] igrnv,
  input  logic [VIDEO_WIDTH-1:0] ibluv,
  output logic [9:0]             ocol,
  output logic [9:0]             orow,
  output logic [VIDEO_WIDTH-1:0] oredv,
  output logic [VIDEO_WIDTH-1:0] ogrnv,
  output logic [VIDEO_WIDTH-1:0] obluv,
  output logic                   oactive,
  output logic                   oframe_start,
  output logic                   olocked,
  output logic                   oerror,
  output logic [7:0]             oerr_count
);

  // Line counters must hold the watchdog limit; frame counters one past a frame.
  localparam int LW = $clog2(2 * TOTAL_COLS + 1);
  localparam int FW = $clog2(TOTAL_ROWS + 2);
  localparam logic [LW-1:0] L_MAX    = '1;
  localparam logic [FW-1:0] F_MAX    = '1;
  localparam logic [LW-1:0] WD_LIM   = LW'(2 * TOTAL_COLS);
  localparam logic [9:0]    COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]    ROW_LAST = 10'(TOTAL_ROWS - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic                   h1_q, h1_d, v1_q, v1_d, h2_q, h2_d, v2_q, v2_d;
  logic [VIDEO_WIDTH-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [9:0]             col_q, col_d, row_q, row_d;
  logic                   frame_start_q, frame_start_d;
  logic                   locked_q, locked_d, error_q, error_d;
  logic [7:0]             err_count_q, err_count_d;
  logic [LW-1:0]          hlen_q, hlen_d, hhigh_q, hhigh_d, wd_q, wd_d;
  logic [FW-1:0]          nlines_q, nlines_d, vlines_q, vlines_d;
  logic                   hseen_q, hseen_d, vseen_q, vseen_d;
  logic                   frame_bad_q, frame_bad_d;
  logic [3:0]             good_q, good_d;

  logic hrise, hfall, vrise;
  logic len_bad, high_bad, wd_fire, nlines_bad, vlines_bad, viol;

  assign hrise = h1_q & ~h2_q;
  assign hfall = ~h1_q & h2_q;
  assign vrise = v1_q & ~v2_q;

  // Next-state logic: pipeline, counters, timing checks and lock FSM.
  always_comb begin
    h1_d = ihsync;
    v1_d = ivsync;
    r1_d = iredv;
    g1_d = igrnv;
    b1_d = ibluv;
    h2_d = h1_q;
    v2_d = v1_q;
    red_d = r1_q;
    grn_d = g1_q;
    blu_d = b1_q;
    frame_start_d = vrise;

    // Free-running position counters, re-anchored on every vsync rise.
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (vrise) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
    end

    // Line length and hsync-high width; checks wait for a first real hrise.
    hseen_d  = hseen_q | hrise;
    hlen_d   = hrise ? LW'(1) : ((hlen_q == L_MAX) ? hlen_q : hlen_q + LW'(1));
    len_bad  = hrise & hseen_q & (hlen_q != LW'(TOTAL_COLS));
    hhigh_d  = '0;
    if (h1_q) hhigh_d = hrise ? LW'(1) : ((hhigh_q == L_MAX) ? hhigh_q : hhigh_q + LW'(1));
    high_bad = hfall & hseen_q & (hhigh_q != LW'(ACTIVE_COLS));

    // Watchdog counts clocks since the last hrise and restarts when it fires.
    wd_fire = ~hrise & (wd_q == WD_LIM);
    wd_d    = (hrise | wd_fire) ? LW'(1) : wd_q + LW'(1);

    // Frame line counts; the hrise coincident with vrise opens the new frame.
    vseen_d    = vseen_q | vrise;
    nlines_bad = vrise & vseen_q & (nlines_q != FW'(TOTAL_ROWS));
    vlines_bad = vrise & vseen_q & (vlines_q != FW'(ACTIVE_ROWS));
    if (vrise) begin
      nlines_d = hrise ? FW'(1) : '0;
      vlines_d = hrise ? FW'(1) : '0;
    end else begin
      nlines_d = (hrise && nlines_q != F_MAX) ? nlines_q + FW'(1) : nlines_q;
      vlines_d = (hrise && v1_q && vlines_q != F_MAX) ? vlines_q + FW'(1) : vlines_q;
    end

    viol        = len_bad | high_bad | wd_fire | nlines_bad | vlines_bad;
    frame_bad_d = vrise ? 1'b0 : (frame_bad_q | viol);

    state_d     = state_q;
    good_d      = good_q;
    error_d     = 1'b0;
    err_count_d = err_count_q;
    unique case (state_q)
      SEARCH: begin
        if (vrise) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (vrise) begin
          if (frame_bad_q | viol) begin
            good_d = '0;
          end else if (good_q + 4'd1 == 4'(LOCK_FRAMES)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end else if (viol) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d = SEARCH;
          error_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State register; reset clears everything so no partial frame survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEARCH;
      h1_q <= 1'b0; v1_q <= 1'b0; h2_q <= 1'b0; v2_q <= 1'b0;
      r1_q <= '0; g1_q <= '0; b1_q <= '0;
      red_q <= '0; grn_q <= '0; blu_q <= '0;
      col_q <= '0; row_q <= '0;
      frame_start_q <= 1'b0; locked_q <= 1'b0; error_q <= 1'b0;
      err_count_q <= '0;
      hlen_q <= '0; hhigh_q <= '0; wd_q <= '0;
      nlines_q <= '0; vlines_q <= '0;
      hseen_q <= 1'b0; vseen_q <= 1'b0; frame_bad_q <= 1'b0;
      good_q <= '0;
    end else begin
      state_q <= state_d;
      h1_q <= h1_d; v1_q <= v1_d; h2_q <= h2_d; v2_q <= v2_d;
      r1_q <= r1_d; g1_q <= g1_d; b1_q <= b1_d;
      red_q <= red_d; grn_q <= grn_d; blu_q <= blu_d;
      col_q <= col_d; row_q <= row_d;
      frame_start_q <= frame_start_d; locked_q <= locked_d; error_q <= error_d;
      err_count_q <= err_count_d;
      hlen_q <= hlen_d; hhigh_q <= hhigh_d; wd_q <= wd_d;
      nlines_q <= nlines_d; vlines_q <= vlines_d;
      hseen_q <= hseen_d; vseen_q <= vseen_d; frame_bad_q <= frame_bad_d;
      good_q <= good_d;
    end
  end

  assign ocol         = col_q;
  assign orow         = row_q;
  assign oredv        = red_q;
  assign ogrnv        = grn_q;
  assign obluv        = blu_q;
  assign oframe_start = frame_start_q;
  assign olocked      = locked_q;
  assign oerror       = error_q;
  assign oerr_count   = err_count_q;
  assign oactive      = locked_q & (col_q < 10'(ACTIVE_COLS)) & (row_q < 10'(ACTIVE_ROWS));

endmodule
